prog_loader: RTL and testbench

//  Streams a program image byte-by-byte into the kcpsmx instruction ROM, then

---
 rtl/prog_loader.sv | 148 ++++++++++++++
 tb/tb_prog_loader.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// prog_loader: receives a length-prefixed, checksummed program image as a byte
// stream, writes each 18-bit instruction into the kcpsmx instruction ROM and
// releases the processor from reset once the checksum matches.
//
// Byte stream handshake: a byte is consumed on a rising edge where
// in_valid && in_ready are both 1. While in_ready is 0 the upstream source
// keeps in_valid/in_data stable and nothing is consumed. There is no ROM
// backpressure: every rom_we pulse is a completed write.
//
// The FSM state is held in the `state` signal; done, error, cpu_reset and
// in_ready are pure decodes of it, so they always agree with the state.
module prog_loader #(
    parameter int ADDR_WIDTH   = 10,
    parameter int INSTR_WIDTH  = 18,
    parameter int PROGRAM_SIZE = 1024
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   load_start,
    input  logic                   in_valid,
    input  logic [7:0]             in_data,
    output logic                   in_ready,
    output logic                   rom_we,
    output logic [ADDR_WIDTH-1:0]  rom_addr,
    output logic [INSTR_WIDTH-1:0] rom_wdata,
    output logic                   cpu_reset,
    output logic                   done,
    output logic                   error,
    output logic [ADDR_WIDTH:0]    word_count
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LEN_HI = 3'd1;
    localparam logic [2:0] S_LEN_LO = 3'd2;
    localparam logic [2:0] S_DATA   = 3'd3;
    localparam logic [2:0] S_CHECK  = 3'd4;
    localparam logic [2:0] S_RUN    = 3'd5;
    localparam logic [2:0] S_ERR    = 3'd6;

    localparam logic [31:0] PROGRAM_SIZE_U = PROGRAM_SIZE;

    logic [2:0]          state;
    logic [15:0]         len;
    logic [1:0]          phase;      // byte position inside the current instruction
    logic [1:0]          b0_q;       // low bits of the first instruction byte
    logic [7:0]          b1_q;       // second instruction byte
    logic [7:0]          checksum;   // running XOR of data bytes

    logic                accept;
    logic [15:0]         len_rx;
    logic [ADDR_WIDTH:0] wc_next;
    logic                last_word;
    logic                too_long;

    assign accept    = in_valid & in_ready;
    assign len_rx    = {len[15:8], in_data};
    assign wc_next   = word_count + {{ADDR_WIDTH{1'b0}}, 1'b1};
    assign last_word = (32'(wc_next) == 32'(len));
    assign too_long  = ({16'd0, len_rx} > PROGRAM_SIZE_U);

    // Status outputs decoded from the FSM state.
    always_comb begin
        in_ready  = (state == S_LEN_HI) || (state == S_LEN_LO) ||
                    (state == S_DATA)   || (state == S_CHECK);
        cpu_reset = (state != S_RUN);
        done      = (state == S_RUN);
        error     = (state == S_ERR);
    end

    // Loader FSM, instruction assembly, ROM write port and checksum.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= S_IDLE;
            len        <= '0;
            phase      <= '0;
            b0_q       <= '0;
            b1_q       <= '0;
            checksum   <= '0;
            rom_we     <= 1'b0;
            rom_addr   <= '0;
            rom_wdata  <= '0;
            word_count <= '0;
        end else begin
            rom_we <= 1'b0;
            case (state)
                S_IDLE, S_RUN, S_ERR: begin
                    if (load_start) begin
                        state      <= S_LEN_HI;
                        word_count <= '0;
                        checksum   <= '0;
                        phase      <= '0;
                    end
                end
                S_LEN_HI: begin
                    if (accept) begin
                        len[15:8] <= in_data;
                        state     <= S_LEN_LO;
                    end
                end
                S_LEN_LO: begin
                    if (accept) begin
                        len <= len_rx;
                        if (too_long) begin
                            state <= S_ERR;
                        end else if (len_rx == 16'd0) begin
                            state <= S_CHECK;
                        end else begin
                            state <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (accept) begin
                        checksum <= checksum ^ in_data;
                        case (phase)
                            2'd0: begin
                                b0_q  <= in_data[1:0];
                                phase <= 2'd1;
                            end
                            2'd1: begin
                                b1_q  <= in_data;
                                phase <= 2'd2;
                            end
                            2'd2: begin
                                phase      <= 2'd0;
                                rom_we     <= 1'b1;
                                rom_addr   <= word_count[ADDR_WIDTH-1:0];
                                rom_wdata  <= INSTR_WIDTH'({b0_q, b1_q, in_data});
                                word_count <= wc_next;
                                if (last_word) begin
                                    state <= S_CHECK;
                                end
                            end
                            default: phase <= 2'd0;
                        endcase
                    end
                end
                S_CHECK: begin
                    if (accept) begin
                        state <= (in_data == checksum) ? S_RUN : S_ERR;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: a per-byte vector table for the basic image plus
// hand-written sequences for error, empty, gapped-stream and reset-abort loads.
// Inputs change 1 time unit after the rising edge; outputs are read there or
// on the falling edge.
module tb_prog_loader;

    // ---------------- clock / reset ----------------
    logic        clk        = 1'b0;
    logic        reset      = 1'b0;
    logic        load_start = 1'b0;
    logic        in_valid   = 1'b0;
    logic [7:0]  in_data    = 8'h00;
    logic        in_ready;
    logic        rom_we;
    logic [9:0]  rom_addr;
    logic [17:0] rom_wdata;
    logic        cpu_reset;
    logic        done;
    logic        error;
    logic [10:0] word_count;

    always #5 clk = ~clk;

    prog_loader #(
        .ADDR_WIDTH  (10),
        .INSTR_WIDTH (18),
        .PROGRAM_SIZE(1024)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .load_start (load_start),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .rom_we     (rom_we),
        .rom_addr   (rom_addr),
        .rom_wdata  (rom_wdata),
        .cpu_reset  (cpu_reset),
        .done       (done),
        .error      (error),
        .word_count (word_count)
    );

    // ---------------- scoreboard state ----------------
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [27:0] exp_q[$];       // expected ROM writes {addr, wdata}
    logic [27:0] mon_exp;
    logic [7:0]  stream_q[$];    // bytes of the image being sent
    bit          we_q[$];        // rom_we expected in the cycle after each byte
    logic [7:0]  dbytes[$];      // data bytes of the image being built

    typedef struct {
        logic [7:0]  data;
        logic        we;
        logic [9:0]  addr;
        logic [17:0] wdata;
        logic        done_e;
        logic        err_e;
        logic        cpu_e;
        logic [10:0] wc;
    } vec_t;

    vec_t tbl[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // Every ROM write must match the next expected write, in order.
    always @(negedge clk) begin
        if (rom_we === 1'b1) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL rom_write_unexpected: got addr %0h data %0h, required no write",
                         rom_addr, rom_wdata);
            end else begin
                mon_exp = exp_q.pop_front();
                if ({rom_addr, rom_wdata} !== mon_exp) begin
                    n_fail++;
                    $display("FAIL rom_write: got addr %0h data %0h, required addr %0h data %0h",
                             rom_addr, rom_wdata, mon_exp[27:18], mon_exp[17:0]);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic pulse_load();
        load_start = 1'b1;
        @(posedge clk); #1;
        load_start = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    // Offer one byte until it is consumed, then check rom_we in the next cycle.
    task automatic send_byte(input logic [7:0] b, input bit exp_we, input bit gaps);
        bit rdy;
        bit ok;
        ok = 1'b0;
        if (gaps) idle($urandom_range(0, 3));
        in_valid = 1'b1;
        in_data  = b;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            rdy = in_ready;
            @(posedge clk); #1;
            if (rdy) begin
                ok = 1'b1;
                break;
            end
        end
        in_valid = 1'b0;
        in_data  = 8'($urandom_range(0, 255));
        if (!ok) begin
            n_checks++;
            n_fail++;
            $display("FAIL accept_timeout: byte %0h not consumed, required consumed within 20 cycles", b);
        end
        check("rom_we_after_byte", 32'(rom_we), 32'(exp_we));
    endtask

    task automatic send_range(input int lo, input int hi, input bit gaps);
        for (int i = lo; i < hi; i++) send_byte(stream_q[i], we_q[i], gaps);
    endtask

    task automatic set_test1_bytes();
        dbytes = '{8'h00, 8'hC3, 8'h01, 8'h03, 8'hFF, 8'hFF};
    endtask

    // Build stream_q/we_q from dbytes and queue the expected ROM writes.
    task automatic build_image(input logic [15:0] len, input bit bad_cs);
        logic [7:0] cs;
        cs = 8'h00;
        stream_q.delete();
        we_q.delete();
        stream_q.push_back(len[15:8]); we_q.push_back(1'b0);
        stream_q.push_back(len[7:0]);  we_q.push_back(1'b0);
        for (int i = 0; i < dbytes.size(); i++) begin
            stream_q.push_back(dbytes[i]);
            we_q.push_back(i % 3 == 2);
            cs = cs ^ dbytes[i];
            if (i % 3 == 2)
                exp_q.push_back({10'(i / 3), dbytes[i-2][1:0], dbytes[i-1], dbytes[i]});
        end
        if (bad_cs) stream_q.push_back((cs == 8'h00) ? 8'h01 : 8'h00);
        else        stream_q.push_back(cs);
        we_q.push_back(1'b0);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_in_ready"},   32'(in_ready),   32'd0);
        check({tag, "_rom_we"},     32'(rom_we),     32'd0);
        check({tag, "_rom_addr"},   32'(rom_addr),   32'd0);
        check({tag, "_rom_wdata"},  32'(rom_wdata),  32'd0);
        check({tag, "_cpu_reset"},  32'(cpu_reset),  32'd1);
        check({tag, "_done"},       32'(done),       32'd0);
        check({tag, "_error"},      32'(error),      32'd0);
        check({tag, "_word_count"}, 32'(word_count), 32'd0);
    endtask

    task automatic check_status(input string tag, input logic d, input logic e, input logic c,
                                input logic [10:0] wc);
        check({tag, "_done"},       32'(done),       32'(d));
        check({tag, "_error"},      32'(error),      32'(e));
        check({tag, "_cpu_reset"},  32'(cpu_reset),  32'(c));
        check({tag, "_word_count"}, 32'(word_count), 32'(wc));
    endtask

    // ---------------- test sequence ----------------
    initial begin
        // Basic image: data XOR = 00^C3^01^03^FF^FF = C1.
        //            data   we    addr    wdata      done  err   cpu   wc
        tbl[0] = '{8'h00, 1'b0, 10'd0, 18'h00000, 1'b0, 1'b0, 1'b1, 11'd0};
        tbl[1] = '{8'h02, 1'b0, 10'd0, 18'h00000, 1'b0, 1'b0, 1'b1, 11'd0};
        tbl[2] = '{8'h00, 1'b0, 10'd0, 18'h00000, 1'b0, 1'b0, 1'b1, 11'd0};
        tbl[3] = '{8'hC3, 1'b0, 10'd0, 18'h00000, 1'b0, 1'b0, 1'b1, 11'd0};
        tbl[4] = '{8'h01, 1'b1, 10'd0, 18'h0C301, 1'b0, 1'b0, 1'b1, 11'd1};
        tbl[5] = '{8'h03, 1'b0, 10'd0, 18'h0C301, 1'b0, 1'b0, 1'b1, 11'd1};
        tbl[6] = '{8'hFF, 1'b0, 10'd0, 18'h0C301, 1'b0, 1'b0, 1'b1, 11'd1};
        tbl[7] = '{8'hFF, 1'b1, 10'd1, 18'h3FFFF, 1'b0, 1'b0, 1'b1, 11'd2};
        tbl[8] = '{8'hC1, 1'b0, 10'd1, 18'h3FFFF, 1'b1, 1'b0, 1'b0, 11'd2};

        reset = 1'b0;
        idle(3);
        check_reset_values("reset");
        reset = 1'b1;
        idle(2);
        check("idle_in_ready", 32'(in_ready), 32'd0);

        // Test 1: basic two-word image from the vector table.
        pulse_load();
        check("t1_in_ready_after_start", 32'(in_ready), 32'd1);
        exp_q.push_back({10'd0, 18'h0C301});
        exp_q.push_back({10'd1, 18'h3FFFF});
        for (int i = 0; i < 9; i++) begin
            send_byte(tbl[i].data, tbl[i].we, 1'b0);
            check($sformatf("t1_addr[%0d]", i),  32'(rom_addr),   32'(tbl[i].addr));
            check($sformatf("t1_wdata[%0d]", i), 32'(rom_wdata),  32'(tbl[i].wdata));
            check($sformatf("t1_done[%0d]", i),  32'(done),       32'(tbl[i].done_e));
            check($sformatf("t1_error[%0d]", i), 32'(error),      32'(tbl[i].err_e));
            check($sformatf("t1_cpu[%0d]", i),   32'(cpu_reset),  32'(tbl[i].cpu_e));
            check($sformatf("t1_wc[%0d]", i),    32'(word_count), 32'(tbl[i].wc));
        end
        idle(3);
        check("t1_done_holds", 32'(done), 32'd1);
        check("t1_pending_writes", 32'(exp_q.size()), 32'd0);

        // Test 2: bad checksum, then retry with load_start ignored mid-load.
        pulse_load();
        check_status("t2_start", 1'b0, 1'b0, 1'b1, 11'd0);
        set_test1_bytes();
        build_image(16'd2, 1'b1);
        send_range(0, stream_q.size(), 1'b0);
        check_status("t2_bad_cs", 1'b0, 1'b1, 1'b1, 11'd2);
        check("t2_in_ready", 32'(in_ready), 32'd0);
        idle(3);
        check("t2_error_sticky", 32'(error), 32'd1);
        check("t2_cpu_held", 32'(cpu_reset), 32'd1);
        pulse_load();
        check("t2_retry_error_clear", 32'(error), 32'd0);
        build_image(16'd2, 1'b0);
        send_range(0, 5, 1'b0);
        check("t2_mid_wc", 32'(word_count), 32'd1);
        pulse_load();
        check("t2_ignored_start_wc", 32'(word_count), 32'd1);
        check("t2_ignored_start_ready", 32'(in_ready), 32'd1);
        send_range(5, stream_q.size(), 1'b0);
        check_status("t2_retry_ok", 1'b1, 1'b0, 1'b0, 11'd2);
        check("t2_pending_writes", 32'(exp_q.size()), 32'd0);

        // Test 3: oversize length 1025 goes to error with no writes.
        pulse_load();
        send_byte(8'h04, 1'b0, 1'b0);
        send_byte(8'h01, 1'b0, 1'b0);
        check_status("t3_len_1025", 1'b0, 1'b1, 1'b1, 11'd0);
        in_valid = 1'b1;
        in_data  = 8'hAA;
        idle(3);
        check("t3_not_ready", 32'(in_ready), 32'd0);
        check("t3_error_holds", 32'(error), 32'd1);
        in_valid = 1'b0;
        check("t3_pending_writes", 32'(exp_q.size()), 32'd0);

        // Test 4: zero-length image.
        pulse_load();
        dbytes.delete();
        build_image(16'd0, 1'b0);
        send_range(0, stream_q.size(), 1'b0);
        check_status("t4_empty", 1'b1, 1'b0, 1'b0, 11'd0);

        // Test 5: basic image with random idle gaps in the stream.
        pulse_load();
        set_test1_bytes();
        build_image(16'd2, 1'b0);
        send_range(0, stream_q.size(), 1'b1);
        check_status("t5_gaps", 1'b1, 1'b0, 1'b0, 11'd2);
        check("t5_pending_writes", 32'(exp_q.size()), 32'd0);

        // Test 6: maximum length 1024 accepted, then reset after 4 data bytes.
        pulse_load();
        send_byte(8'h04, 1'b0, 1'b0);
        send_byte(8'h00, 1'b0, 1'b0);
        check("t6_len_1024_no_error", 32'(error), 32'd0);
        check("t6_len_1024_ready", 32'(in_ready), 32'd1);
        exp_q.push_back({10'd0, 18'h23456});
        send_byte(8'h12, 1'b0, 1'b0);
        send_byte(8'h34, 1'b0, 1'b0);
        send_byte(8'h56, 1'b1, 1'b0);
        send_byte(8'h78, 1'b0, 1'b0);
        check("t6_wc_before_reset", 32'(word_count), 32'd1);
        reset = 1'b0;
        idle(1);
        check_reset_values("t6_reset");
        reset = 1'b1;
        idle(1);
        pulse_load();
        set_test1_bytes();
        build_image(16'd2, 1'b0);
        send_range(0, stream_q.size(), 1'b0);
        check_status("t6_reload", 1'b1, 1'b0, 1'b0, 11'd2);
        idle(2);
        check("final_pending_writes", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required test completion");
        $fatal(1, "watchdog");
    end

endmodule
